mult_sequencer: RTL



---
 rtl/mult_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
// Sequencer and 9-bit add/subtract stage of the signed shift-add multiplier.
// Drives the clear/load/shift controls of the external A and B shift registers and holds the X sign bit.
module mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] A_in,
  input  logic             M,
  output logic [WIDTH-1:0] Sum,
  output logic             Load_A,
  output logic             Clear_A,
  output logic             Load_B,
  output logic             Shift_En,
  output logic             X,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HALT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            x_nxt;
  logic            last;
  logic            sub;
  logic [WIDTH:0]  a_ext, s_ext, r;

  assign last = (count == CW'(WIDTH - 1));

  // The multiplier's sign bit has negative weight, so the final partial product is subtracted.
  always_comb begin
    a_ext = {A_in[WIDTH-1], A_in};
    s_ext = {S[WIDTH-1], S};
    sub   = (state == ADD) && last;
    r     = sub ? (a_ext - s_ext) : (a_ext + s_ext);
    Sum   = r[WIDTH-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
      X     <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      X     <= x_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    x_nxt     = X;
    Load_A    = 1'b0;
    Clear_A   = 1'b0;
    Load_B    = 1'b0;
    Shift_En  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (Run) begin
          state_nxt = CLEAR;
        end else if (ClearA_LoadB) begin
          Clear_A = 1'b1;
          Load_B  = 1'b1;
          x_nxt   = 1'b0;
        end
      end
      CLEAR: begin
        Busy      = 1'b1;
        Clear_A   = 1'b1;
        x_nxt     = 1'b0;
        count_nxt = '0;
        state_nxt = ADD;
      end
      ADD: begin
        Busy = 1'b1;
        // r[WIDTH] is the true sign of the partial sum; it becomes the next shift-in bit.
        if (M) begin
          Load_A = 1'b1;
          x_nxt  = r[WIDTH];
        end
        state_nxt = SHIFT;
      end
      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
        if (last) begin
          state_nxt = HALT;
        end else begin
          count_nxt = count + 1'b1;
          state_nxt = ADD;
        end
      end
      HALT: begin
        Done = 1'b1;
        if (!Run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
